sort_stream_adapter: RTL and testbench

//  Stream front/back end for the 8-entry selection-sort circuit. Collects N bytes from a

---
 rtl/sort_stream_adapter_if.sv | 33 +++
 rtl/sort_stream_adapter.sv | 140 ++++++++++++++
 tb/tb_sort_stream_adapter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_stream_adapter_if.sv
// Handshake bundle between the stream adapter, its producer/consumer and the sorter core.
// master = adapter side, slave = environment (producer, consumer, sorter) side.
interface sort_stream_adapter_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 3
);
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic          srt_wr;
  logic [AW-1:0] srt_addr;
  logic [W-1:0]  srt_data;
  logic          srt_start;
  logic          srt_ready;
  logic [W-1:0]  srt_dout;

  modport master (
    input  in_valid, in_data, out_ready, srt_ready, srt_dout,
    output in_ready, out_valid, out_data, out_last, busy,
           srt_wr, srt_addr, srt_data, srt_start
  );

  modport slave (
    output in_valid, in_data, out_ready, srt_ready, srt_dout,
    input  in_ready, out_valid, out_data, out_last, busy,
           srt_wr, srt_addr, srt_data, srt_start
  );
endinterface

// File: rtl/sort_stream_adapter.sv
// Stream front/back end for the N-entry selection sorter: fill, kick, wait, drain.
// Define SORT_STREAM_DESC_EN to emit each frame largest-first instead of ascending.
module sort_stream_adapter #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 3
) (
  input logic                   clk,
  input logic                   nrst,
  sort_stream_adapter_if.master bus
);

  typedef enum logic [2:0] {StFill, StKick, StWlo, StWhi, StRd, StCap, StOut} state_e;

  localparam logic [AW-1:0] LastIdx = AW'(N - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  data_q, data_d;
  logic          wr_q, wr_d;
  logic          start_q, start_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [AW-1:0] cnt_inc;

  function automatic logic [AW-1:0] rd_idx(input logic [AW-1:0] c);
`ifdef SORT_STREAM_DESC_EN
    return LastIdx - c;
`else
    return c;
`endif
  endfunction

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_d        = 1'b0;
    start_d     = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      StFill: begin
        if (bus.in_valid) begin
          wr_d   = 1'b1;
          addr_d = cnt_q;
          data_d = bus.in_data;
          if (cnt_q == LastIdx) begin
            cnt_d   = '0;
            state_d = StKick;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      // The write of the last beat is on the bus during the first KICK cycle, so it
      // lands before any start pulse can follow.
      StKick: begin
        if (bus.srt_ready) begin
          start_d = 1'b1;
          state_d = StWlo;
        end
      end
      StWlo: begin
        if (!bus.srt_ready) state_d = StWhi;
      end
      // Read address is registered on entry to RD so srt_dout is valid during CAP.
      StWhi: begin
        if (bus.srt_ready) begin
          cnt_d   = '0;
          addr_d  = rd_idx('0);
          state_d = StRd;
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        out_data_d  = bus.srt_dout;
        out_valid_d = 1'b1;
        out_last_d  = (cnt_q == LastIdx);
        state_d     = StOut;
      end
      StOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (cnt_q == LastIdx) begin
            cnt_d   = '0;
            state_d = StFill;
          end else begin
            cnt_d   = cnt_inc;
            addr_d  = rd_idx(cnt_inc);
            state_d = StRd;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StFill;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      start_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      start_q     <= start_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = (state_q == StFill);
  assign bus.busy      = (state_q != StFill);
  assign bus.srt_wr    = wr_q;
  assign bus.srt_addr  = addr_q;
  assign bus.srt_data  = data_q;
  assign bus.srt_start = start_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_sort_stream_adapter.sv
// Bench for sort_stream_adapter: behavioural sorter core, queue-based frame scoreboard,
// vector table, directed backpressure / ignored-input / mid-sort reset sequences, random frames.
module tb_sort_stream_adapter;
  localparam int unsigned N  = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned AW = 3;
`ifdef SORT_STREAM_DESC_EN
  localparam bit Desc = 1'b1;
`else
  localparam bit Desc = 1'b0;
`endif

  typedef logic [W-1:0] frame_t [N];
  typedef struct {
    frame_t din;
    frame_t dasc;
    bit     noise;
  } vec_t;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sort_stream_adapter_if #(.W(W), .AW(AW)) bus ();

  sort_stream_adapter #(.N(N), .W(W), .AW(AW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Consumer ready: either random per cycle or set directly by the test.
  bit   rand_ready_en = 1'b0;
  logic rnd_ready     = 1'b1;
  logic manual_ready  = 1'b1;
  assign bus.out_ready = rand_ready_en ? rnd_ready : manual_ready;
  always @(posedge clk) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  // Sorter core model: sync write, registered read, sorts ascending after a random latency.
  frame_t mem;
  int     lat;
  function automatic frame_t sort_frame(input frame_t a);
    frame_t r = a;
    logic [W-1:0] t;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (r[j] > r[j+1]) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
        end
    return r;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus.srt_ready <= 1'b1;
      bus.srt_dout  <= '0;
      lat           <= 0;
    end else begin
      bus.srt_dout <= mem[bus.srt_addr];
      if (bus.srt_wr) mem[bus.srt_addr] <= bus.srt_data;
      if (bus.srt_start && bus.srt_ready) begin
        bus.srt_ready <= 1'b0;
        lat           <= $urandom_range(2, 6);
      end else if (!bus.srt_ready) begin
        if (lat <= 1) begin
          mem           <= sort_frame(mem);
          bus.srt_ready <= 1'b1;
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  // Scoreboard and protocol monitor, sampled on the falling edge.
  logic [W-1:0] in_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_d[$];
  bit           got_l[$];
  bit           prev_acc = 1'b0;
  int           prev_idx = 0;
  logic [W-1:0] prev_dat = '0;
  bit           prev_hold = 1'b0;
  logic [W-1:0] hold_data = '0;
  logic         hold_last = 1'b0;
  int           starts = 0;
  int           out_idx = 0;
  logic [W-1:0] e;

  always @(negedge clk) begin
    if (!nrst) begin
      in_q.delete();
      exp_q.delete();
      prev_acc  = 1'b0;
      prev_hold = 1'b0;
      starts    = 0;
      out_idx   = 0;
    end else begin
      chk("srt_wr_after_accept", bus.srt_wr, prev_acc);
      if (prev_acc) begin
        chk("srt_addr", bus.srt_addr, prev_idx);
        chk("srt_data", bus.srt_data, prev_dat);
      end
      chk("in_ready_vs_busy", bus.in_ready, !bus.busy);
      if (bus.srt_start) begin
        starts++;
        chk("start_with_wr", bus.srt_wr, 1'b0);
      end
      if (prev_hold) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_data", bus.out_data, hold_data);
        chk("hold_last", bus.out_last, hold_last);
      end
      prev_acc = bus.in_valid && bus.in_ready;
      if (prev_acc) begin
        prev_idx = in_q.size();
        prev_dat = bus.in_data;
        in_q.push_back(bus.in_data);
        if (in_q.size() == N) begin
          in_q.sort();
          if (Desc) in_q.reverse();
          foreach (in_q[i]) exp_q.push_back(in_q[i]);
          in_q.delete();
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
      hold_last = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back(bus.out_data);
        got_l.push_back(bus.out_last);
        chk("exp_available", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_out_data", bus.out_data, e);
        end
        chk("sb_out_last", bus.out_last, out_idx == N - 1);
        if (out_idx == N - 1) begin
          chk("start_pulses_per_frame", starts, 1);
          starts  = 0;
          out_idx = 0;
        end else begin
          out_idx++;
        end
      end
    end
  end

  task automatic send_beat(input logic [W-1:0] v, input int gap);
    bit done;
    done = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("in_accept_timeout", done, 1'b1);
  endtask

  // Waits for a full output frame; with noise, drives junk input beats meanwhile.
  task automatic wait_frame(input bit noise);
    int i;
    i = 0;
    while (got_d.size() < N && i < 3000) begin
      @(posedge clk); #1;
      bus.in_valid = noise && (got_d.size() < N);
      bus.in_data  = W'($urandom);
      i++;
    end
    bus.in_valid = 1'b0;
    chk("frame_timeout", got_d.size(), N);
  endtask

  task automatic check_frame(input string name, input frame_t dasc);
    for (int i = 0; i < N; i++) begin
      if (i < got_d.size()) begin
        chk({name, "_data"}, got_d[i], dasc[Desc ? N - 1 - i : i]);
        chk({name, "_last"}, got_l[i], i == N - 1);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    got_d.delete();
    got_l.delete();
    for (int i = 0; i < N; i++) send_beat(v.din[i], 0);
    wait_frame(v.noise);
    check_frame(name, v.dasc);
  endtask

  vec_t vecs[6];
  int   k;

  initial begin
    vecs[0].din = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4};
    vecs[0].dasc = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    vecs[0].noise = 1'b0;
    vecs[1].din = '{8'd9, 8'd9, 8'd1, 8'd9, 8'd1, 8'd9, 8'd9, 8'd9};
    vecs[1].dasc = '{8'd1, 8'd1, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
    vecs[1].noise = 1'b0;
    vecs[2] = vecs[0];
    vecs[2].noise = 1'b1;
    vecs[3].din = '{8'hff, 8'h00, 8'h80, 8'h7f, 8'h01, 8'hfe, 8'h10, 8'h01};
    vecs[3].dasc = '{8'h00, 8'h01, 8'h01, 8'h10, 8'h7f, 8'h80, 8'hfe, 8'hff};
    vecs[3].noise = 1'b0;
    vecs[4].din = '{8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33};
    vecs[4].dasc = vecs[4].din;
    vecs[4].noise = 1'b1;
    vecs[5].din = '{8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0};
    vecs[5].dasc = '{8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70};
    vecs[5].noise = 1'b0;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1 nrst = 1'b0;
    #11;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_srt_wr", bus.srt_wr, 1'b0);
    chk("rst_srt_start", bus.srt_start, 1'b0);
    chk("rst_srt_addr", bus.srt_addr, 0);
    chk("rst_srt_data", bus.srt_data, 0);
    @(posedge clk); #3;
    nrst = 1'b1;
    @(posedge clk); #1;

    // Vector table: T1, T3, T4-style junk input while busy, extremes, equal, reversed.
    for (int v = 0; v < 6; v++) run_vec(vecs[v], $sformatf("tbl%0d", v));

    // Backpressure: consumer stalls 3 cycles while beat 2 is presented.
    got_d.delete();
    got_l.delete();
    for (int i = 0; i < N; i++) send_beat(vecs[0].din[i], 0);
    k = 0;
    while (got_d.size() < 2 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    manual_ready = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("bp_beat2_seen", bus.out_valid, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_data", bus.out_data, vecs[0].dasc[Desc ? N - 3 : 2]);
      chk("bp_last", bus.out_last, 1'b0);
    end
    @(posedge clk); #1;
    manual_ready = 1'b1;
    wait_frame(1'b0);
    check_frame("bp", vecs[0].dasc);

    // Reset while the sorter is busy (WHI), then a clean frame.
    got_d.delete();
    got_l.delete();
    for (int i = 0; i < N; i++) send_beat(vecs[5].din[i], 0);
    k = 0;
    while (!bus.srt_start && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_start_seen", bus.srt_start, 1'b1);
    @(negedge clk);
    chk("rst_mid_sorter_busy", bus.srt_ready, 1'b0);
    @(posedge clk); #1;
    nrst = 1'b0;
    #2;
    chk("rst_mid_busy", bus.busy, 1'b0);
    chk("rst_mid_out_valid", bus.out_valid, 1'b0);
    chk("rst_mid_in_ready", bus.in_ready, 1'b1);
    chk("rst_mid_srt_start", bus.srt_start, 1'b0);
    @(posedge clk); #3;
    nrst = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[1], "after_rst");

    // Random frames with random input gaps, junk input and consumer backpressure.
    rand_ready_en = 1'b1;
    for (int f = 0; f < 24; f++) begin
      got_d.delete();
      got_l.delete();
      for (int i = 0; i < N; i++)
        send_beat(W'($urandom_range(0, (f % 2 == 1) ? 3 : 255)), $urandom_range(0, 2));
      wait_frame(1'($urandom_range(0, 1)));
    end
    rand_ready_en = 1'b0;
    repeat (4) @(posedge clk);
    chk("leftover_expected", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d errors so far, required completion",
             errors);
    $fatal(1);
  end

endmodule
